lane_merge_41: RTL and testbench
================================

# lane_merge_41

Serial lane merger for the Zigbee baseband path: accepts one 4-bit group (one bit per lane) from the lane-split stage's upstream side and re-serializes it onto a single bit stream in lane order 0→3. It is the reassembly counterpart of the 1:4 lane demultiplexer. It sits between the per-lane processing and the serial chip stream. Both sides use valid/ready handshakes, and back-to-back groups stream with no bubble.

## Interface
- LSB_FIRST, 1, 1: emit lane 0 first (inData[0]…inData[3]); 0: emit lane 3 first.
- inClk  input  1  system clock, all state on rising edge.
- inRst_n  input  1  asynchronous active-low reset.
- inData  input  4  group to merge; bit k = lane k.
- inValid  input  1  inData is valid.
- outReady  output  1  block can accept a group this cycle.
- outData  output  1  current serial bit.
- outValid  output  1  outData is valid.
- inReady  input  1  downstream accepts outData this cycle.
- outSel  output  2  lane index of the bit on outData.
- outLast  output  1  current beat is the final beat of the group.

## Operation
- Group accept: inValid && outReady at a rising edge. Serial beat transfer: outValid && inReady at a rising edge.
- FSM states:
  - IDLE: no group held.
  - SHIFT: holding a group; beat counter 0..3 selects the lane.
- IDLE → SHIFT on group accept. Capture inData in a 4-bit hold register and clear the beat counter.
- In SHIFT, the counter increments on every serial transfer.
- On the transfer of the last beat: go to SHIFT with counter 0 if a new group is accepted in the same cycle, otherwise go to IDLE.
- outReady = (state==IDLE) || (outLast && inReady). It is combinational from state and inReady.
- outData = hold[beat] when LSB_FIRST=1, hold[3−beat] when LSB_FIRST=0.
- outSel carries the lane index actually driven on outData.
- outLast = 1 on beat 3, or on the parity beat when MERGE_PARITY_EN is defined.
- While outValid && !inReady: outData, outSel and outLast hold stable and the counter does not advance.
- inData is ignored whenever outReady=0. No group is ever dropped or overwritten.
- Reset: state IDLE, hold=4'b0000, beat=0.
  - Output values during and after reset: outValid=0, outData=0, outSel=2'b00, outLast=0, outReady=1.
- Reset asserted mid-group discards the remainder of the group. No partial beats follow the release of reset.

## Timing
- Group accepted at edge N → beat 0 on outData after edge N, valid during cycle N+1.
- outValid, outData, outSel and outLast are registered. Only outReady is combinational.
- Sustained throughput is 1 bit/cycle: a group every 4 cycles (5 with parity) when inValid and inReady are held high.
- Last-beat transfer and next-group accept in the same cycle: the next group's beat 0 appears in the following cycle with no idle cycle.
- Simultaneous inValid=1 and inReady=0 on the last beat: outReady=0 and no accept; the last beat is held.
- No-group gap: outValid deasserts the cycle after the last transfer and outData returns to 0.

## Configuration
- MERGE_PARITY_EN defined: each group emits a 5th beat after lane 3.
  - The 5th beat's outData is the even parity of the group: ^hold.
  - outSel=2'b11 on the parity beat; outLast moves to the parity beat.
  - outReady takes effect on the parity beat instead of beat 3.
- MERGE_PARITY_EN undefined: exactly 4 beats per group; no parity logic is synthesized.

## Test plan
- Reset then idle: inRst_n low 3 cycles → outValid=0, outData=0, outSel=0, outLast=0, outReady=1; all hold after release with inValid=0.
- Single group, LSB_FIRST=1, inData=4'b1011, inReady=1 → outData 1,1,0,1 on outSel 0,1,2,3; outLast only on the 4th beat; outValid low afterwards.
- Back-to-back groups 4'b0001 then 4'b1110, inValid and inReady constantly 1, LSB_FIRST=0 → 8 consecutive valid beats 0,0,0,1,1,1,1,0 with no gap; outReady pulses high only on last beats.
- Backpressure: inData=4'b0110, inReady low for 3 cycles during beat 1 → outData=1 and outSel=1 held stable; no beat lost or duplicated; full sequence 0,1,1,0.
- Reset mid-group after beat 1 of 4'b1111 → outValid=0 immediately; after release, a new group 4'b0000 emits exactly 0,0,0,0.
- MERGE_PARITY_EN defined, inData=4'b0111 → beats 1,1,1,0 then parity beat 1 with outSel=3 and outLast=1; outReady=0 on beat 3.

Source files
------------

// File: rtl/lane_merge_41.sv
// 4:1 lane merger: serializes a 4-bit lane group onto one valid/ready bit stream.
// Optional MERGE_PARITY_EN appends an even-parity beat (^hold) after lane 3.
module lane_merge_41 #(
  parameter int LSB_FIRST = 1
) (
  input  logic       inClk,
  input  logic       inRst_n,
  input  logic [3:0] inData,
  input  logic       inValid,
  output logic       outReady,
  output logic       outData,
  output logic       outValid,
  input  logic       inReady,
  output logic [1:0] outSel,
  output logic       outLast
);

`ifdef MERGE_PARITY_EN
  localparam logic [2:0] LAST_BEAT = 3'd4;
`else
  localparam logic [2:0] LAST_BEAT = 3'd3;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_nx;
  logic [3:0] hold, hold_nx;
  logic [2:0] beat, beat_nx;
  logic       accept, xfer;
  logic       bit_nx;
  logic [1:0] sel_nx;

  assign outReady = (state == IDLE) || (outLast && inReady);

  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    beat_nx  = beat;
    accept   = inValid && outReady;
    xfer     = outValid && inReady;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SHIFT;
          hold_nx  = inData;
          beat_nx  = '0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (beat == LAST_BEAT) begin
            beat_nx = '0;
            if (accept) hold_nx  = inData;
            else        state_nx = IDLE;
          end else begin
            beat_nx = beat + 3'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next-state values.
  always_comb begin
    sel_nx = (LSB_FIRST != 0) ? beat_nx[1:0] : 2'd3 - beat_nx[1:0];
    bit_nx = hold_nx[sel_nx];
`ifdef MERGE_PARITY_EN
    if (beat_nx == 3'd4) begin
      bit_nx = ^hold_nx;
      sel_nx = 2'b11;
    end
`endif
    if (state_nx == IDLE) begin
      bit_nx = 1'b0;
      sel_nx = '0;
    end
  end

  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      state    <= IDLE;
      hold     <= '0;
      beat     <= '0;
      outValid <= 1'b0;
      outData  <= 1'b0;
      outSel   <= '0;
      outLast  <= 1'b0;
    end else begin
      state    <= state_nx;
      hold     <= hold_nx;
      beat     <= beat_nx;
      outValid <= (state_nx == SHIFT);
      outData  <= bit_nx;
      outSel   <= sel_nx;
      outLast  <= (state_nx == SHIFT) && (beat_nx == LAST_BEAT);
    end
  end

endmodule

// File: tb/tb_lane_merge_41.sv
// Directed bench for lane_merge_41: LSB-first and MSB-first instances driven in lockstep.
module tb_lane_merge_41;

`ifdef MERGE_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = '0;
  logic       vin = 1'b0;
  logic       rdy = 1'b1;

  logic       l_ready, l_data, l_valid, l_last;
  logic [1:0] l_sel;
  logic       m_ready, m_data, m_valid, m_last;
  logic [1:0] m_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_merge_41 #(.LSB_FIRST(1)) u_lsb (
    .inClk(clk), .inRst_n(rst_n), .inData(din), .inValid(vin),
    .outReady(l_ready), .outData(l_data), .outValid(l_valid),
    .inReady(rdy), .outSel(l_sel), .outLast(l_last)
  );

  lane_merge_41 #(.LSB_FIRST(0)) u_msb (
    .inClk(clk), .inRst_n(rst_n), .inData(din), .inValid(vin),
    .outReady(m_ready), .outData(m_data), .outValid(m_valid),
    .inReady(rdy), .outSel(m_sel), .outLast(m_last)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat k of group h on both instances; k==4 is the parity beat.
  task automatic beat_chk(input string tag, input logic [3:0] h, input int k, input logic ready_exp);
    logic [1:0] ls, ms;
    logic       lb, mb;
    ls = 2'(k);
    ms = 2'(3 - k);
    lb = h[ls];
    mb = h[ms];
    if (k == 4) begin
      ls = 2'b11; ms = 2'b11; lb = ^h; mb = ^h;
    end
    chk({tag, " l_valid"}, l_valid, 1'b1);
    chk({tag, " l_data"},  l_data,  lb);
    chk({tag, " l_sel"},   l_sel,   ls);
    chk({tag, " l_last"},  l_last,  k == NB - 1);
    chk({tag, " l_ready"}, l_ready, ready_exp);
    chk({tag, " m_valid"}, m_valid, 1'b1);
    chk({tag, " m_data"},  m_data,  mb);
    chk({tag, " m_sel"},   m_sel,   ms);
    chk({tag, " m_last"},  m_last,  k == NB - 1);
    chk({tag, " m_ready"}, m_ready, ready_exp);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " l_valid"}, l_valid, 1'b0);
    chk({tag, " l_data"},  l_data,  1'b0);
    chk({tag, " l_sel"},   l_sel,   2'b00);
    chk({tag, " l_last"},  l_last,  1'b0);
    chk({tag, " l_ready"}, l_ready, 1'b1);
    chk({tag, " m_valid"}, m_valid, 1'b0);
    chk({tag, " m_data"},  m_data,  1'b0);
    chk({tag, " m_ready"}, m_ready, 1'b1);
  endtask

  // One isolated group with inReady held high, followed by an idle check.
  task automatic run_group(input string tag, input logic [3:0] h);
    din = h; vin = 1'b1; rdy = 1'b1;
    tick();
    vin = 1'b0; din = '0;
    for (int k = 0; k < NB; k++) begin
      beat_chk($sformatf("%s b%0d", tag, k), h, k, k == NB - 1);
      tick();
    end
    idle_chk({tag, " after"});
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    repeat (3) tick();
    idle_chk("rst");
    rst_n = 1'b1;
    repeat (2) tick();
    idle_chk("idle");

    // Single group
    run_group("single", 4'b1011);

    // Back-to-back groups with no bubble
    din = 4'b0001; vin = 1'b1; rdy = 1'b1;
    tick();
    for (int k = 0; k < NB; k++) begin
      beat_chk($sformatf("b2b A b%0d", k), 4'b0001, k, k == NB - 1);
      if (k == NB - 1) din = 4'b1110;
      tick();
    end
    for (int k = 0; k < NB; k++) begin
      beat_chk($sformatf("b2b B b%0d", k), 4'b1110, k, k == NB - 1);
      if (k == NB - 1) vin = 1'b0;
      tick();
    end
    idle_chk("b2b after");

    // Backpressure on beat 1 and on the last beat, with a competing group offered
    din = 4'b0110; vin = 1'b1; rdy = 1'b1;
    tick();
    din = 4'b1111;
    beat_chk("bp b0", 4'b0110, 0, 1'b0);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      beat_chk($sformatf("bp stall%0d", i), 4'b0110, 1, 1'b0);
      tick();
    end
    beat_chk("bp b1 final", 4'b0110, 1, 1'b0);
    rdy = 1'b1;
    for (int k = 2; k < NB; k++) begin
      tick();
      if (k == NB - 1) begin
        rdy = 1'b0;
        #1;
        beat_chk("bp last stall", 4'b0110, k, 1'b0);
        tick();
        beat_chk("bp last held", 4'b0110, k, 1'b0);
        vin = 1'b0; rdy = 1'b1;
        #1;
      end
      beat_chk($sformatf("bp b%0d", k), 4'b0110, k, k == NB - 1);
    end
    tick();
    idle_chk("bp after");

    // Reset mid-group discards the remainder
    din = 4'b1111; vin = 1'b1; rdy = 1'b1;
    tick();
    vin = 1'b0;
    beat_chk("mid b0", 4'b1111, 0, 1'b0);
    tick();
    beat_chk("mid b1", 4'b1111, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    idle_chk("mid rst");
    tick();
    rst_n = 1'b1;
    tick();
    idle_chk("mid release");
    run_group("post rst", 4'b0000);

    // Parity-relevant group (4 beats in the default build)
    run_group("p0111", 4'b0111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100us");
    $fatal(1, "timeout");
  end

endmodule
